// File: rtl/sargantana_icache_tag_ctrl.sv
// Instruction-cache tag controller: arbitrates flush, refill and fetch lookup
// onto NUM_WAYS single-cycle tag memories and builds the lookup hit/way response.
module sargantana_icache_tag_ctrl #(
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          lkp_valid_i,
    output logic                          lkp_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]     lkp_idx_i,
    input  logic [TAG_WIDHT-1:0]          lkp_tag_i,
    output logic                          lkp_rsp_o,
    output logic                          lkp_hit_o,
    output logic [NUM_WAYS-1:0]           lkp_way_o,
    output logic                          lkp_multi_o,

    input  logic                          rfl_valid_i,
    output logic                          rfl_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]     rfl_idx_i,
    input  logic [TAG_WIDHT-1:0]          rfl_tag_i,
    input  logic [NUM_WAYS-1:0]           rfl_way_i,

    input  logic                          flush_i,
    output logic                          flush_busy_o,

    output logic [NUM_WAYS-1:0]           tag_req_o,
    output logic                          tag_we_o,
    output logic                          tag_vbit_o,
    output logic                          tag_flush_o,
    output logic [TAG_ADDR_WIDHT-1:0]     tag_addr_o,
    output logic [TAG_WIDHT-1:0]          tag_data_o,
    input  logic [NUM_WAYS*TAG_WIDHT-1:0] tag_data_i,
    input  logic [NUM_WAYS-1:0]           tag_vbit_i
);

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   rsp_q, rsp_d;
    logic [TAG_WIDHT-1:0]   cmp_tag_q, cmp_tag_d;

    logic [NUM_WAYS-1:0]    match_c;
    logic [NUM_WAYS-1:0]    first_c;
    logic                   multi_c;
    logic                   rsp_live_c;

    // State, pending-response flag and pending compare tag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= FLUSH;
            rsp_q     <= 1'b0;
            cmp_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            cmp_tag_q <= cmp_tag_d;
        end
    end

    // Next state, arbitration (flush > refill > lookup) and memory command
    always_comb begin
        state_d      = state_q;
        rsp_d        = 1'b0;
        cmp_tag_d    = cmp_tag_q;
        rfl_ready_o  = 1'b0;
        lkp_ready_o  = 1'b0;
        flush_busy_o = 1'b0;
        tag_req_o    = '0;
        tag_we_o     = 1'b0;
        tag_vbit_o   = 1'b0;
        tag_flush_o  = 1'b0;
        tag_addr_o   = '0;
        tag_data_o   = '0;

        case (state_q)
            FLUSH: begin
                flush_busy_o = 1'b1;
                tag_flush_o  = 1'b1;
                state_d      = DRAIN;
            end
            DRAIN: begin
                flush_busy_o = 1'b1;
                state_d      = IDLE;
            end
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else begin
                    rfl_ready_o = 1'b1;
                    lkp_ready_o = !rfl_valid_i;
                    if (rfl_valid_i) begin
                        tag_req_o  = rfl_way_i;
                        tag_we_o   = 1'b1;
                        tag_vbit_o = 1'b1;
                        tag_addr_o = rfl_idx_i;
                        tag_data_o = rfl_tag_i;
                    end else if (lkp_valid_i) begin
                        tag_req_o  = '1;
                        tag_addr_o = lkp_idx_i;
                        rsp_d      = 1'b1;
                        cmp_tag_d  = lkp_tag_i;
                    end
                end
            end
            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    // Per-way tag compare against the pending lookup tag
    always_comb begin
        match_c = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            match_c[w] = tag_vbit_i[w] &&
                         (tag_data_i[w*TAG_WIDHT +: TAG_WIDHT] == cmp_tag_q);
        end
    end

    // Lowest matching way and more-than-one-match detection
    assign first_c = match_c & (~match_c + NUM_WAYS'(1));
    assign multi_c = |(match_c & (match_c - NUM_WAYS'(1)));

    // A flush arriving with the response forces a miss; memory outputs are
    // only looked at while a response is pending
    assign rsp_live_c  = rsp_q && !flush_i;
    assign lkp_rsp_o   = rsp_q;
    assign lkp_hit_o   = rsp_live_c && (|match_c);
    assign lkp_way_o   = rsp_live_c ? first_c : '0;
    assign lkp_multi_o = rsp_live_c && multi_c;

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Bench for sargantana_icache_tag_ctrl: behavioural tag memories, a set-level
// reference model, and a scoreboard that checks every lookup response.
module tb_sargantana_icache_tag_ctrl;

    localparam int unsigned NW = 4;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned TW = 20;

    typedef struct packed {
        logic          hit;
        logic [NW-1:0] way;
        logic          multi;
    } rsp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              lkp_valid_i = 1'b0;
    logic              lkp_ready_o;
    logic [AW-1:0]     lkp_idx_i = '0;
    logic [TW-1:0]     lkp_tag_i = '0;
    logic              lkp_rsp_o;
    logic              lkp_hit_o;
    logic [NW-1:0]     lkp_way_o;
    logic              lkp_multi_o;
    logic              rfl_valid_i = 1'b0;
    logic              rfl_ready_o;
    logic [AW-1:0]     rfl_idx_i = '0;
    logic [TW-1:0]     rfl_tag_i = '0;
    logic [NW-1:0]     rfl_way_i = '0;
    logic              flush_i = 1'b0;
    logic              flush_busy_o;
    logic [NW-1:0]     tag_req_o;
    logic              tag_we_o;
    logic              tag_vbit_o;
    logic              tag_flush_o;
    logic [AW-1:0]     tag_addr_o;
    logic [TW-1:0]     tag_data_o;
    logic [NW*TW-1:0]  tag_data_i;
    logic [NW-1:0]     tag_vbit_i;

    sargantana_icache_tag_ctrl #(
        .NUM_WAYS(NW), .TAG_DEPTH(DEPTH), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o),
        .lkp_idx_i(lkp_idx_i), .lkp_tag_i(lkp_tag_i),
        .lkp_rsp_o(lkp_rsp_o), .lkp_hit_o(lkp_hit_o),
        .lkp_way_o(lkp_way_o), .lkp_multi_o(lkp_multi_o),
        .rfl_valid_i(rfl_valid_i), .rfl_ready_o(rfl_ready_o),
        .rfl_idx_i(rfl_idx_i), .rfl_tag_i(rfl_tag_i), .rfl_way_i(rfl_way_i),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
        .tag_flush_o(tag_flush_o), .tag_addr_o(tag_addr_o),
        .tag_data_o(tag_data_o), .tag_data_i(tag_data_i), .tag_vbit_i(tag_vbit_i)
    );

    always #5 clk_i = ~clk_i;

    // Tag memories: 1-cycle read/write; read port shows junk when not read
    logic [TW-1:0] mem_t [NW][DEPTH];
    logic          mem_v [NW][DEPTH];
    always @(posedge clk_i) begin
        for (int w = 0; w < NW; w++) begin
            if (tag_flush_o) begin
                for (int i = 0; i < DEPTH; i++) mem_v[w][i] <= 1'b0;
            end
            if (!tag_flush_o && tag_req_o[w] && tag_we_o) begin
                mem_t[w][tag_addr_o] <= tag_data_o;
                mem_v[w][tag_addr_o] <= tag_vbit_o;
            end
            if (!tag_flush_o && tag_req_o[w] && !tag_we_o) begin
                tag_data_i[w*TW +: TW] <= mem_t[w][tag_addr_o];
                tag_vbit_i[w]          <= mem_v[w][tag_addr_o];
            end else begin
                tag_data_i[w*TW +: TW] <= TW'($urandom);
                tag_vbit_i[w]          <= 1'($urandom);
            end
        end
    end

    // Reference model state
    logic [TW-1:0] ref_t [NW][DEPTH];
    logic          ref_v [NW][DEPTH];
    int            busy;
    logic          pend_v;
    rsp_t          pend_exp;
    rsp_t          exp_q[$];
    rsp_t          mon_r;

    logic          chk_en = 1'b0;
    logic          e_lrdy, e_rrdy, e_busy, e_tflush, e_we;
    logic [NW-1:0] e_req;

    int checks = 0;
    int errors = 0;

    function automatic rsp_t ref_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
        rsp_t r;
        int   n;
        r = '0;
        n = 0;
        for (int w = 0; w < NW; w++) begin
            if (ref_v[w][idx] && ref_t[w][idx] == tag) begin
                if (n == 0) r.way = NW'(1 << w);
                n++;
            end
        end
        r.hit   = (n > 0);
        r.multi = (n > 1);
        return r;
    endfunction

    task automatic ref_clear();
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < DEPTH; i++) ref_v[w][i] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One IDLE-or-busy cycle of stimulus plus the model's view of it
    task automatic cyc(input logic fl, input logic rv, input logic [AW-1:0] ridx,
                       input logic [TW-1:0] rtag, input logic [NW-1:0] rway,
                       input logic lv, input logic [AW-1:0] lidx, input logic [TW-1:0] ltag);
        logic idle;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        flush_i = fl; rfl_valid_i = rv; rfl_idx_i = ridx; rfl_tag_i = rtag; rfl_way_i = rway;
        lkp_valid_i = lv; lkp_idx_i = lidx; lkp_tag_i = ltag;

        idle     = (busy == 0);
        e_busy   = !idle;
        e_tflush = (busy == 2);
        e_rrdy   = idle && !fl;
        e_lrdy   = e_rrdy && !rv;
        e_we     = e_rrdy && rv;
        e_req    = e_we ? rway : ((e_lrdy && lv) ? '1 : '0);

        if (pend_v) exp_q.push_back(fl ? rsp_t'(0) : pend_exp);
        pend_v = 1'b0;

        if (!idle) begin
            busy--;
        end else if (fl) begin
            busy = 2;
            ref_clear();
        end else if (rv) begin
            for (int w = 0; w < NW; w++) begin
                if (rway[w]) begin
                    ref_t[w][ridx] = rtag;
                    ref_v[w][ridx] = 1'b1;
                end
            end
        end else if (lv) begin
            pend_exp = ref_lookup(lidx, ltag);
            pend_v   = 1'b1;
        end
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic lkp(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b1, idx, tag);
    endtask

    task automatic rfl(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [NW-1:0] way);
        cyc(1'b0, 1'b1, idx, tag, way, 1'b0, '0, '0);
    endtask

    // Hold reset for n cycles; the model drops any pending response
    task automatic do_reset(input int n);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        flush_i = 1'b0; rfl_valid_i = 1'b0; lkp_valid_i = 1'b0;
        pend_v = 1'b0;
        ref_clear();
        e_busy = 1'b1; e_tflush = 1'b1; e_rrdy = 1'b0; e_lrdy = 1'b0; e_we = 1'b0; e_req = '0;
        chk_en = 1'b1;
        repeat (n - 1) @(posedge clk_i);
        busy = 2;
    endtask

    // Monitor: control outputs every cycle, responses against the scoreboard
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("lkp_ready", 32'(lkp_ready_o), 32'(e_lrdy));
            chk("rfl_ready", 32'(rfl_ready_o), 32'(e_rrdy));
            chk("flush_busy", 32'(flush_busy_o), 32'(e_busy));
            chk("tag_flush", 32'(tag_flush_o), 32'(e_tflush));
            chk("tag_we", 32'(tag_we_o), 32'(e_we));
            chk("tag_req", 32'(tag_req_o), 32'(e_req));
            if (lkp_rsp_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp @%0t: got lkp_rsp_o=1 expected 0", $time);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("rsp_hit", 32'(lkp_hit_o), 32'(mon_r.hit));
                    chk("rsp_way", 32'(lkp_way_o), 32'(mon_r.way));
                    chk("rsp_multi", 32'(lkp_multi_o), 32'(mon_r.multi));
                end
            end else begin
                chk("quiet_rsp_fields", 32'({lkp_hit_o, lkp_way_o, lkp_multi_o}), 32'(0));
            end
            if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_rsp @%0t: got lkp_rsp_o=0 expected 1", $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        busy   = 2;
        pend_v = 1'b0;
        ref_clear();
        do_reset(3);

        // Flush sequence after reset, lookups held off
        lkp(6'd5, 20'h1);
        lkp(6'd5, 20'h1);

        rfl(6'd5, 20'h01234, 4'b0100);
        lkp(6'd5, 20'h01234);
        lkp(6'd5, 20'h01235);
        lkp(6'd6, 20'h01234);

        // All three requesters together: flush only
        cyc(1'b1, 1'b1, 6'd7, 20'h00077, 4'b0001, 1'b1, 6'd5, 20'h01234);
        nop(); nop();
        lkp(6'd5, 20'h01234);

        rfl(6'd9, 20'hABCDE, 4'b0101);
        lkp(6'd9, 20'hABCDE);
        nop();

        // Flush sampled in the response cycle forces a miss
        lkp(6'd9, 20'hABCDE);
        cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        nop(); nop();

        // Back-to-back lookups, then reset mid-stream
        rfl(6'd3, 20'h00003, 4'b1000);
        rfl(6'd3, 20'h00003, 4'b0010);
        for (int i = 0; i < 8; i++) lkp(AW'(i % 4), 20'h00003);
        lkp(6'd3, 20'h00003);
        lkp(6'd3, 20'h00003);
        do_reset(2);
        nop(); nop();

        // Randomized traffic on a small index/tag space to force hits
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cyc(($urandom_range(0, 47) == 0),
                    ($urandom_range(0, 3) == 0),
                    AW'($urandom_range(0, 7)),
                    TW'($urandom_range(0, 3)),
                    NW'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)),
                    TW'($urandom_range(0, 3)));
            end
        end
        nop(); nop();
        @(negedge clk_i);
        @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
